stack_pointer_pair: RTL and testbench

- Clocked model of the twin stack-pointer registers driven by the stack controller's strobes (n_load_x, up_x, down_x, n_oe_d_x, n_oe_ia_x).
- Holds SP0 and SP1, each loadable from the data bus and incrementable/decrementable by strobe pulses.
- Drives the selected SP back onto the data bus for reads.
- Drives the selected SP as the low address byte of the stack bank for indirect accesses.

---
 rtl/stack_pkg.sv | 25 ++
 rtl/sp_channel.sv | 56 +++++
 rtl/stack_pointer_pair.sv | 76 +++++++
 tb/tb_stack_pointer_pair.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the twin stack-pointer block: widths, reset value,
// controller register map and the per-channel update kinds.
package stack_pkg;

  localparam int         SP_W_DEF     = 8;
  localparam logic [7:0] SP_RESET_DEF = 8'h00;

  localparam logic [15:0] ADDR_SP0    = 16'hFC00;
  localparam logic [15:0] ADDR_SP1    = 16'hFC01;
  localparam logic [15:0] ADDR_INCDEC = 16'hFC02;
  localparam logic [15:0] ADDR_ENABLE = 16'hFC03;

  localparam int INCDEC_INC0 = 0;
  localparam int INCDEC_INC1 = 1;
  localparam int INCDEC_DEC0 = 2;
  localparam int INCDEC_DEC1 = 3;

  typedef enum logic [1:0] {
    UPD_HOLD,
    UPD_LOAD,
    UPD_INC,
    UPD_DEC
  } upd_t;

endpackage

// File: rtl/sp_channel.sv
// One stack pointer: rising-edge detectors on the active-low up/down pulses,
// load-over-count priority and the pointer register itself.
module sp_channel
  import stack_pkg::*;
#(
  parameter int              SP_W     = SP_W_DEF,
  parameter logic [SP_W-1:0] SP_RESET = SP_RESET_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            n_load,
  input  logic            up,
  input  logic            down,
  input  logic [SP_W-1:0] d_in,
  output logic [SP_W-1:0] sp
);

  logic prev_up;
  logic prev_down;
  logic up_evt;
  logic down_evt;
  upd_t upd;

  // An event is the release of a pulse: line high now, low on the previous edge.
  assign up_evt   = up & ~prev_up;
  assign down_evt = down & ~prev_down;

  always_comb begin
    upd = UPD_HOLD;
    if (!n_load)
      upd = UPD_LOAD;
    else if (up_evt && !down_evt)
      upd = UPD_INC;
    else if (down_evt && !up_evt)
      upd = UPD_DEC;
  end

  // Detectors idle high so a strobe held low across reset yields one event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_up   <= 1'b1;
      prev_down <= 1'b1;
      sp        <= SP_RESET;
    end else begin
      prev_up   <= up;
      prev_down <= down;
      case (upd)
        UPD_LOAD: sp <= d_in;
        UPD_INC:  sp <= sp + 1'b1;
        UPD_DEC:  sp <= sp - 1'b1;
        default:  sp <= sp;
      endcase
    end
  end

endmodule

// File: rtl/stack_pointer_pair.sv
// Twin stack pointers with data-bus read-back, indirect-address output and a
// sticky flag for both pointers being selected onto the same path.
module stack_pointer_pair
  import stack_pkg::*;
#(
  parameter int              SP_W     = SP_W_DEF,
  parameter logic [SP_W-1:0] SP_RESET = SP_RESET_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            n_load_0,
  input  logic            n_load_1,
  input  logic            up_0,
  input  logic            up_1,
  input  logic            down_0,
  input  logic            down_1,
  input  logic            n_oe_d_0,
  input  logic            n_oe_d_1,
  input  logic            n_oe_ia_0,
  input  logic            n_oe_ia_1,
  input  logic [SP_W-1:0] d_in,
  output logic [SP_W-1:0] d_out,
  output logic            d_oe,
  output logic [SP_W-1:0] ia_out,
  output logic            ia_oe,
  output logic [SP_W-1:0] sp0,
  output logic [SP_W-1:0] sp1,
  output logic            err_conflict
);

  sp_channel #(.SP_W(SP_W), .SP_RESET(SP_RESET)) u_ch0 (
    .clk    (clk),
    .rst    (rst),
    .n_load (n_load_0),
    .up     (up_0),
    .down   (down_0),
    .d_in   (d_in),
    .sp     (sp0)
  );

  sp_channel #(.SP_W(SP_W), .SP_RESET(SP_RESET)) u_ch1 (
    .clk    (clk),
    .rst    (rst),
    .n_load (n_load_1),
    .up     (up_1),
    .down   (down_1),
    .d_in   (d_in),
    .sp     (sp1)
  );

  assign d_oe  = ~(n_oe_d_0 & n_oe_d_1);
  assign ia_oe = ~(n_oe_ia_0 & n_oe_ia_1);

  // SP0 wins on both paths when both selects are active.
  always_comb begin
    d_out = '0;
    if (!n_oe_d_0)
      d_out = sp0;
    else if (!n_oe_d_1)
      d_out = sp1;

    ia_out = '0;
    if (!n_oe_ia_0)
      ia_out = sp0;
    else if (!n_oe_ia_1)
      ia_out = sp1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_conflict <= 1'b0;
    else if ((!n_oe_d_0 && !n_oe_d_1) || (!n_oe_ia_0 && !n_oe_ia_1))
      err_conflict <= 1'b1;
  end

endmodule

// File: tb/tb_stack_pointer_pair.sv
// Scoreboard bench: the driver applies each cycle's inputs on the falling edge
// and queues the model's expected post-edge outputs; the monitor checks them.
module tb_stack_pointer_pair;

  logic       clk = 1'b0;
  logic       rst;
  logic       n_load_0, n_load_1, up_0, up_1, down_0, down_1;
  logic       n_oe_d_0, n_oe_d_1, n_oe_ia_0, n_oe_ia_1;
  logic [7:0] d_in;
  logic [7:0] d_out, ia_out, sp0, sp1;
  logic       d_oe, ia_oe, err_conflict;

  stack_pointer_pair #(.SP_W(8), .SP_RESET(8'h00)) dut (
    .clk          (clk),
    .rst          (rst),
    .n_load_0     (n_load_0),
    .n_load_1     (n_load_1),
    .up_0         (up_0),
    .up_1         (up_1),
    .down_0       (down_0),
    .down_1       (down_1),
    .n_oe_d_0     (n_oe_d_0),
    .n_oe_d_1     (n_oe_d_1),
    .n_oe_ia_0    (n_oe_ia_0),
    .n_oe_ia_1    (n_oe_ia_1),
    .d_in         (d_in),
    .d_out        (d_out),
    .d_oe         (d_oe),
    .ia_out       (ia_out),
    .ia_oe        (ia_oe),
    .sp0          (sp0),
    .sp1          (sp1),
    .err_conflict (err_conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] n_load;
    logic [1:0] up;
    logic [1:0] down;
    logic [1:0] n_oe_d;
    logic [1:0] n_oe_ia;
    logic [7:0] d_in;
  } stim_t;

  typedef struct {
    logic [7:0] sp0, sp1, d_out, ia_out;
    logic       d_oe, ia_oe, err;
  } exp_t;

  exp_t  exp_q[$];
  stim_t cur;
  int    vectors = 0;
  int    miscompares = 0;

  // Reference model state: pointer values as integers, last sampled strobe levels.
  int m_sp[2];
  bit m_last_up[2];
  bit m_last_down[2];
  bit m_err;

  task automatic modelStep(input stim_t s, output exp_t e);
    bit rose_up, rose_down;
    if (s.rst) begin
      m_sp = '{0, 0};
      m_last_up = '{1'b1, 1'b1};
      m_last_down = '{1'b1, 1'b1};
      m_err = 1'b0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        rose_up   = s.up[ch] && !m_last_up[ch];
        rose_down = s.down[ch] && !m_last_down[ch];
        if (!s.n_load[ch])
          m_sp[ch] = int'(s.d_in);
        else if (rose_up && !rose_down)
          m_sp[ch] = (m_sp[ch] + 1) % 256;
        else if (rose_down && !rose_up)
          m_sp[ch] = (m_sp[ch] + 255) % 256;
        m_last_up[ch]   = s.up[ch];
        m_last_down[ch] = s.down[ch];
      end
      if (s.n_oe_d == 2'b00 || s.n_oe_ia == 2'b00)
        m_err = 1'b1;
    end
    e.sp0  = 8'(m_sp[0]);
    e.sp1  = 8'(m_sp[1]);
    e.err  = m_err;
    e.d_oe = (s.n_oe_d != 2'b11);
    e.d_out = !s.n_oe_d[0] ? e.sp0 : (!s.n_oe_d[1] ? e.sp1 : 8'h00);
    e.ia_oe = (s.n_oe_ia != 2'b11);
    e.ia_out = !s.n_oe_ia[0] ? e.sp0 : (!s.n_oe_ia[1] ? e.sp1 : 8'h00);
  endtask

  task automatic applyStimulus();
    exp_t e;
    @(negedge clk);
    rst       = cur.rst;
    n_load_0  = cur.n_load[0];
    n_load_1  = cur.n_load[1];
    up_0      = cur.up[0];
    up_1      = cur.up[1];
    down_0    = cur.down[0];
    down_1    = cur.down[1];
    n_oe_d_0  = cur.n_oe_d[0];
    n_oe_d_1  = cur.n_oe_d[1];
    n_oe_ia_0 = cur.n_oe_ia[0];
    n_oe_ia_1 = cur.n_oe_ia[1];
    d_in      = cur.d_in;
    modelStep(cur, e);
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic idle();
    cur.rst = 1'b0;
    cur.n_load = 2'b11;
    cur.up = 2'b11;
    cur.down = 2'b11;
    cur.n_oe_d = 2'b11;
    cur.n_oe_ia = 2'b11;
  endtask

  task automatic loadBoth(input logic [7:0] v0, input logic [7:0] v1);
    idle();
    cur.n_load = 2'b10;
    cur.d_in = v0;
    applyStimulus();
    cur.n_load = 2'b01;
    cur.d_in = v1;
    applyStimulus();
    idle();
    applyStimulus();
  endtask

  task automatic pulseReset(input logic [1:0] up_level);
    idle();
    cur.up = up_level;
    cur.rst = 1'b1;
    applyStimulus();
    applyStimulus();
    cur.rst = 1'b0;
    applyStimulus();
    applyStimulus();
  endtask

  // Monitor: every output sampled 1 ns after the edge the expectation refers to.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        checkOutput("sp0", sp0, e.sp0);
        checkOutput("sp1", sp1, e.sp1);
        checkOutput("d_out", d_out, e.d_out);
        checkOutput("d_oe", {7'b0, d_oe}, {7'b0, e.d_oe});
        checkOutput("ia_out", ia_out, e.ia_out);
        checkOutput("ia_oe", {7'b0, ia_oe}, {7'b0, e.ia_oe});
        checkOutput("err_conflict", {7'b0, err_conflict}, {7'b0, e.err});
      end
    end
  end

  initial begin
    int budget;
    cur.d_in = 8'h00;
    idle();
    cur.rst = 1'b1;
    rst = 1'b1;
    {n_load_0, n_load_1, up_0, up_1, down_0, down_1} = 6'b111111;
    {n_oe_d_0, n_oe_d_1, n_oe_ia_0, n_oe_ia_1} = 4'b1111;
    d_in = 8'h00;
    applyStimulus();
    applyStimulus();
    idle();
    applyStimulus();

    // Two-cycle load: last sampled value stays.
    cur.n_load = 2'b10;
    cur.d_in = 8'h3A;
    applyStimulus();
    cur.d_in = 8'h5C;
    applyStimulus();
    idle();
    applyStimulus();

    // Increment wraps 0xFF -> 0x00 only on the release of a 3-cycle pulse.
    loadBoth(8'hFF, 8'h00);
    cur.up = 2'b10;
    repeat (3) applyStimulus();
    idle();
    applyStimulus();
    applyStimulus();

    // Decrement wraps 0x00 -> 0xFF; coincident up/down release holds.
    cur.down = 2'b01;
    applyStimulus();
    idle();
    applyStimulus();
    cur.up = 2'b01;
    cur.down = 2'b01;
    applyStimulus();
    applyStimulus();
    idle();
    applyStimulus();

    // Read and indirect muxes, then a data-bus conflict.
    loadBoth(8'h10, 8'h20);
    cur.n_oe_d = 2'b01;
    applyStimulus();
    cur.n_oe_d = 2'b11;
    cur.n_oe_ia = 2'b10;
    applyStimulus();
    cur.n_oe_ia = 2'b01;
    applyStimulus();
    cur.n_oe_ia = 2'b11;
    cur.n_oe_d = 2'b00;
    applyStimulus();
    idle();
    repeat (3) applyStimulus();

    // Strobe held low across reset release gives one event; held high gives none.
    pulseReset(2'b10);
    idle();
    applyStimulus();
    applyStimulus();
    pulseReset(2'b11);
    idle();
    applyStimulus();

    // Load wins over a same-cycle down event.
    cur.down = 2'b01;
    applyStimulus();
    cur.down = 2'b11;
    cur.n_load = 2'b01;
    cur.d_in = 8'h80;
    applyStimulus();
    idle();
    applyStimulus();

    // Randomised traffic with occasional resets and bus selects.
    for (int i = 0; i < 3000; i++) begin
      cur.rst = ($urandom_range(149) == 0);
      for (int ch = 0; ch < 2; ch++) begin
        cur.n_load[ch]  = ($urandom_range(7) != 0);
        cur.up[ch]      = ($urandom_range(2) != 0);
        cur.down[ch]    = ($urandom_range(2) != 0);
        cur.n_oe_d[ch]  = ($urandom_range(3) != 0);
        cur.n_oe_ia[ch] = ($urandom_range(3) != 0);
      end
      if ($urandom_range(3) != 0 && cur.n_oe_d == 2'b00)
        cur.n_oe_d = 2'b01;
      if ($urandom_range(3) != 0 && cur.n_oe_ia == 2'b00)
        cur.n_oe_ia = 2'b10;
      cur.d_in = 8'($urandom_range(255));
      applyStimulus();
    end

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
